// File: rtl/sort_pkg.sv
// Shared helpers for the bitonic sorter: stage count, lane pairing and pair direction.
package sort_pkg;

  localparam int DEFAULT_N      = 8;
  localparam int DEFAULT_DATA_W = 32;

  function automatic int sort_stages(input int n);
    int l;
    l = $clog2(n);
    return l * (l + 1) / 2;
  endfunction

  function automatic int partner(input int i, input int j);
    return i ^ j;
  endfunction

  // Ascending when the k-bit of the lane index is clear, flipped by the vector's desc bit.
  function automatic logic dir_up(input int i, input int k, input logic desc);
    return logic'((i & k) == 0) ^ desc;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/sort_cas.sv
// One compare-exchange cell: lane a takes the min (up=1) or max (up=0) of the pair.
// With SORT_TAG_EN the original index rides along and breaks data ties.
module sort_cas #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 3
) (
  input  logic              up,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
`ifdef SORT_TAG_EN
  input  logic [IDX_W-1:0]  a_idx,
  input  logic [IDX_W-1:0]  b_idx,
  output logic [IDX_W-1:0]  a_res_idx,
  output logic [IDX_W-1:0]  b_res_idx,
`endif
  output logic [DATA_W-1:0] a_res,
  output logic [DATA_W-1:0] b_res
);

  logic swap;

`ifdef SORT_TAG_EN
  logic [DATA_W+IDX_W-1:0] key_a, key_b;
  assign key_a     = {a_data, a_idx};
  assign key_b     = {b_data, b_idx};
  assign a_res_idx = swap ? b_idx : a_idx;
  assign b_res_idx = swap ? a_idx : b_idx;
`else
  logic [DATA_W-1:0] key_a, key_b;
  assign key_a = a_data;
  assign key_b = b_data;
`endif

  // Strict compares: equal keys never swap.
  assign swap  = up ? (key_a > key_b) : (key_a < key_b);
  assign a_res = swap ? b_data : a_data;
  assign b_res = swap ? a_data : b_data;

endmodule

// File: rtl/sort_bitonic_pipe.sv
// Pipelined bitonic sorter, one compare-exchange layer per registered stage, valid/ready flow.
// Optional macro SORT_TAG_EN adds out_idx and index tie-breaking.
module sort_bitonic_pipe
  import sort_pkg::*;
#(
  parameter int N      = 8,
  parameter int DATA_W = 32,
  localparam int LOG_N  = $clog2(N),
  localparam int STAGES = sort_stages(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_desc,
  input  logic [N*DATA_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_desc,
  output logic [N*DATA_W-1:0] out_data,
`ifdef SORT_TAG_EN
  output logic [N*LOG_N-1:0]  out_idx,
`endif
  output logic                busy
);

  if (!is_pow2(N)) begin : g_bad_n
    $error("sort_bitonic_pipe: N must be a power of two and >= 2");
  end

  logic [DATA_W-1:0] lane_reg  [STAGES][N];
  logic [DATA_W-1:0] stage_in  [STAGES][N];
  logic [DATA_W-1:0] stage_out [STAGES][N];
`ifdef SORT_TAG_EN
  logic [LOG_N-1:0]  idx_reg   [STAGES][N];
  logic [LOG_N-1:0]  idx_in    [STAGES][N];
  logic [LOG_N-1:0]  idx_out   [STAGES][N];
`endif
  logic [STAGES-1:0] valid_reg;
  logic [STAGES-1:0] desc_reg;
  logic [STAGES-1:0] stage_desc;
  logic              stall;

  assign out_valid = valid_reg[STAGES-1];
  assign out_desc  = desc_reg[STAGES-1];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign busy      = |valid_reg;

  for (genvar gs = 0; gs < STAGES; gs++) begin : g_in
    if (gs == 0) begin : g_first
      assign stage_desc[gs] = in_desc;
    end else begin : g_next
      assign stage_desc[gs] = desc_reg[gs-1];
    end
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      if (gs == 0) begin : g_first
        assign stage_in[gs][gi] = in_data[gi*DATA_W +: DATA_W];
`ifdef SORT_TAG_EN
        assign idx_in[gs][gi]   = LOG_N'(gi);
`endif
      end else begin : g_next
        assign stage_in[gs][gi] = lane_reg[gs-1][gi];
`ifdef SORT_TAG_EN
        assign idx_in[gs][gi]   = idx_reg[gs-1][gi];
`endif
      end
    end
  end

  // Merge phase k = 2^gp, step j = k/2 .. 1 maps to stage gp*(gp-1)/2 + gq.
  for (genvar gp = 1; gp <= LOG_N; gp++) begin : g_merge
    for (genvar gq = 0; gq < gp; gq++) begin : g_step
      localparam int S = gp * (gp - 1) / 2 + gq;
      localparam int K = 1 << gp;
      localparam int J = 1 << (gp - 1 - gq);
      for (genvar gi = 0; gi < N; gi++) begin : g_pair
        if ((gi & J) == 0) begin : g_cas
          localparam int B = partner(gi, J);
          sort_cas #(.DATA_W(DATA_W), .IDX_W(LOG_N)) u_cas (
            .up        (dir_up(gi, K, stage_desc[S])),
            .a_data    (stage_in[S][gi]),
            .b_data    (stage_in[S][B]),
`ifdef SORT_TAG_EN
            .a_idx     (idx_in[S][gi]),
            .b_idx     (idx_in[S][B]),
            .a_res_idx (idx_out[S][gi]),
            .b_res_idx (idx_out[S][B]),
`endif
            .a_res     (stage_out[S][gi]),
            .b_res     (stage_out[S][B])
          );
        end
      end
    end
  end

  // Whole pipeline advances together or freezes together; bubbles travel to the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      desc_reg  <= '0;
      for (int s = 0; s < STAGES; s++) begin
        for (int i = 0; i < N; i++) begin
          lane_reg[s][i] <= '0;
`ifdef SORT_TAG_EN
          idx_reg[s][i]  <= '0;
`endif
        end
      end
    end else if (!stall) begin
      valid_reg <= STAGES'({valid_reg, in_valid});
      desc_reg  <= stage_desc;
      for (int s = 0; s < STAGES; s++) begin
        for (int i = 0; i < N; i++) begin
          lane_reg[s][i] <= stage_out[s][i];
`ifdef SORT_TAG_EN
          idx_reg[s][i]  <= idx_out[s][i];
`endif
        end
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_out
    assign out_data[gi*DATA_W +: DATA_W] = lane_reg[STAGES-1][gi];
`ifdef SORT_TAG_EN
    assign out_idx[gi*LOG_N +: LOG_N]    = idx_reg[STAGES-1][gi];
`endif
  end

endmodule

// File: tb/tb_sort_bitonic_pipe.sv
// Directed self-checking bench for sort_bitonic_pipe (N=8, DATA_W=32).
module tb_sort_bitonic_pipe;

  localparam int N     = 8;
  localparam int DW    = 32;
  localparam int LOG_N = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic            in_desc;
  logic [N*DW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_desc;
  logic [N*DW-1:0] out_data;
  logic            busy;
`ifdef SORT_TAG_EN
  logic [N*LOG_N-1:0] out_idx;
`endif

  int checks = 0;
  int errors = 0;

  sort_bitonic_pipe #(.N(N), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_desc   (in_desc),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_desc  (out_desc),
    .out_data  (out_data),
`ifdef SORT_TAG_EN
    .out_idx   (out_idx),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*DW-1:0] pack(input logic [DW-1:0] e [N]);
    logic [N*DW-1:0] r;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = e[k];
    return r;
  endfunction

  // Vector v holds v*16 + a permutation of 0..7; odd vectors are sorted descending.
  function automatic logic [N*DW-1:0] bp_vec(input int v);
    logic [N*DW-1:0] r;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = 32'(v * 16 + ((k * 3 + v) % 8));
    return r;
  endfunction

  function automatic logic [N*DW-1:0] bp_exp(input int v);
    logic [N*DW-1:0] r;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = 32'(v * 16 + ((v % 2) != 0 ? 7 - k : k));
    return r;
  endfunction

  logic [DW-1:0]   ev [N];
  logic [N*DW-1:0] last_data;
  logic            prev_stall;
  int              sent;
  int              rcv;
  int              seen;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_desc   = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #2;
    check("reset_out_valid", N*DW'(out_valid), '0);
    check("reset_busy",      N*DW'(busy),      '0);
    check("reset_out_desc",  N*DW'(out_desc),  '0);
    check("reset_out_data",  out_data,         '0);
    check("reset_in_ready",  N*DW'(in_ready),  N*DW'(1));
    tick();
    rst_n = 1'b1;
    tick();

    // Ascending, six-cycle latency, single-cycle output pulse
    ev = '{7, 3, 6, 0, 5, 1, 4, 2};
    in_data = pack(ev); in_desc = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("asc_not_early", N*DW'(out_valid), '0);
    tick();
    ev = '{0, 1, 2, 3, 4, 5, 6, 7};
    check("asc_valid", N*DW'(out_valid), N*DW'(1));
    check("asc_data",  out_data, pack(ev));
    check("asc_desc",  N*DW'(out_desc), '0);
    tick();
    check("asc_one_cycle", N*DW'(out_valid), '0);

    // Descending, same data
    ev = '{7, 3, 6, 0, 5, 1, 4, 2};
    in_data = pack(ev); in_desc = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    ev = '{7, 6, 5, 4, 3, 2, 1, 0};
    check("desc_valid", N*DW'(out_valid), N*DW'(1));
    check("desc_data",  out_data, pack(ev));
    check("desc_flag",  N*DW'(out_desc), N*DW'(1));
    tick();

    // Ties and extremes
    ev = '{32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF, 5, 5, 5, 0};
    in_data = pack(ev); in_desc = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    ev = '{0, 0, 0, 5, 5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    check("ties_valid", N*DW'(out_valid), N*DW'(1));
    check("ties_data",  out_data, pack(ev));
`ifdef SORT_TAG_EN
    check("ties_idx", N*DW'(out_idx),
          N*DW'({3'd3, 3'd0, 3'd6, 3'd5, 3'd4, 3'd7, 3'd2, 3'd1}));
`endif
    tick();

    // Backpressure: 10 vectors streamed, consumer stalls in cycles 8..12
    sent = 0; rcv = 0; prev_stall = 1'b0; last_data = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = !(cyc >= 8 && cyc <= 12);
      in_valid  = (sent < 10);
      in_data   = bp_vec(sent);
      in_desc   = sent[0];
      #1;
      check("bp_in_ready", N*DW'(in_ready), N*DW'(!(cyc >= 8 && cyc <= 12)));
      if (prev_stall) check("bp_hold", out_data, last_data);
      if (out_valid && out_ready) begin
        check("bp_data", out_data, bp_exp(rcv));
        check("bp_desc", N*DW'(out_desc), N*DW'(rcv[0]));
        rcv++;
      end
      prev_stall = out_valid && !out_ready;
      last_data  = out_data;
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
      if (rcv == 10) break;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_sent",     N*DW'(sent), N*DW'(10));
    check("bp_received", N*DW'(rcv),  N*DW'(10));
    check("bp_no_extra", N*DW'(out_valid), '0);
    check("bp_drained",  N*DW'(busy), '0);

    // Reset mid-flight discards everything
    ev = '{9, 8, 7, 6, 5, 4, 3, 2};
    in_data = pack(ev); in_desc = 1'b0; in_valid = 1'b1;
    tick();
    tick();
    check("rst_busy_before", N*DW'(busy), N*DW'(1));
    rst_n = 1'b0;
    #1;
    check("rst_busy_async",  N*DW'(busy),      '0);
    check("rst_valid_async", N*DW'(out_valid), '0);
    check("rst_data_async",  out_data,         '0);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid) seen++;
    end
    check("rst_no_output", N*DW'(seen), '0);
    check("rst_idle_busy", N*DW'(busy), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
